rr_mux_select_arb: RTL and testbench
====================================

Name: rr_mux_select_arb

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 data mux.
- Four requesters (a, b, c, d) compete for the shared mux output.
- Drives the mux select pair s0/s1 plus a one-hot grant and a valid flag.
- A grant is held until the owner signals done or drops its request.

Parameters:
- CNT_W, 8, width of the wrapping grant counter gnt_count.
- MAX_HOLD, 16, maximum cycles a grant may be held. Used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit0=a, bit1=b, bit2=c, bit3=d.
- done  input  1  current owner finished; sampled only while valid=1.
- gnt  output  4  one-hot grant, registered; 0 when idle.
- s0  output  1  mux select MSB, registered.
- s1  output  1  mux select LSB, registered.
- valid  output  1  a grant is active and the mux output is meaningful.
- gnt_count  output  CNT_W  total grants issued, wraps modulo 2^CNT_W.
- timeout  output  1  one-cycle pulse on a forced release.

Behaviour:
- Select encoding matches the mux exactly:
  - a: s0=0, s1=0
  - b: s0=0, s1=1
  - c: s0=1, s1=0
  - d: s0=1, s1=1
  - i.e. winner index = {s0,s1}.
- Reset, asserted asynchronously: gnt=0, s0=0, s1=0, valid=0, gnt_count=0, timeout=0, state=IDLE, last_idx=3, hold_cnt=0.
  - last_idx=3 means the first search starts at a.
  - Reset mid-grant drops the grant immediately, with no done required.
- All outputs are registered. Nothing is combinational from req or done.
- FSM, 2 states:
  - IDLE: valid=0, gnt=0; s0/s1 hold their last value.
    - If req!=0 at a clock edge: select the winner, go to GRANT.
    - Latency: req seen at edge N gives gnt/valid/s0/s1 at edge N, visible in cycle N+1.
  - GRANT: valid=1 and gnt=onehot(cur).
    - Release condition, sampled each edge: done=1, OR req[cur]=0, OR (ARB_TIMEOUT_EN and hold_cnt==MAX_HOLD-1).
    - On release: last_idx<=cur. If any req bit is set (including req[cur]), re-arbitrate in the same edge. Back-to-back grant, valid stays 1, no idle cycle.
    - If req==0 at release: go to IDLE, valid<=0, gnt<=0.
- Winner search: circular scan from last_idx+1 upward (3 wraps to 0). The first set bit wins.
  - The just-released owner wins again only if it is the sole requester.
- gnt_count increments by 1 on every new grant, including back-to-back regrants. 2^CNT_W-1 wraps to 0.
- hold_cnt clears to 0 on every new grant and increments each cycle the grant is held.
- Request lines are not masked. A requester whose req is 0 is never granted.
- done while valid=0 is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A grant held MAX_HOLD cycles without release is forced off.
  - timeout pulses 1 for the cycle following the forced-release edge.
  - Then the normal release/re-arbitration rules apply.
- Undefined:
  - No forced release; the owner holds indefinitely.
  - hold_cnt logic is absent.
  - timeout is tied to 0.

Test Plan:
- Reset check: assert reset with req=4'b1111 and done=0, then release.
  - While in reset: gnt=0, valid=0, s0=s1=0, gnt_count=0.
  - After the first edge: gnt=4'b0001, s0=0, s1=0, valid=1, gnt_count=1.
- Rotation: hold req=4'b1111 and pulse done for 1 cycle, four times.
  - Grant sequence: a, b, c, d, then a again.
  - {s0,s1} sequence: 00, 01, 10, 11, 00.
  - valid never drops; gnt_count=5.
- Sparse request: req=4'b1010, last owner b.
  - After release, gnt=4'b1000, s0=1, s1=1.
  - Then req=4'b0010 with done: b is regranted (sole requester).
- Request drop: owner c, req goes 4'b0100 to 4'b0000 with done=0.
  - Next edge: valid=0, gnt=0, state IDLE.
  - A later req=4'b0001 grants a with 1-cycle latency.
- Async reset mid-grant: owner d, assert reset between clock edges.
  - Outputs go to reset values immediately, without a clock edge.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=4'b0011, a granted, done never asserted.
  - After 4 grant cycles, timeout=1 for one cycle and b is granted.
  - With the macro undefined: a holds for 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_mux_select_arb.sv
// Four-way round-robin arbiter driving the select pair of a downstream 4:1 mux.
// Optional forced release after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_mux_select_arb #(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic             done,
  output logic [3:0]       gnt,
  output logic             s0,
  output logic             s1,
  output logic             valid,
  output logic [CNT_W-1:0] gnt_count,
  output logic             timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Circular scan starting one past 'last'; the i==4 step lands on 'last'
  // itself, so the previous owner only wins when nobody else is asking.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       last_idx_q, last_idx_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] gnt_count_q, gnt_count_d;

  logic             natural_rel;
  logic             forced_rel;
  logic             grant_new;
  logic [1:0]       win;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  assign forced_rel = (hold_cnt_q == 8'(MAX_HOLD - 1));
`else
  assign forced_rel = 1'b0;
`endif

  assign natural_rel = done | ~req[cur_q];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cur_d       = cur_q;
    last_idx_d  = last_idx_q;
    gnt_d       = gnt_q;
    valid_d     = valid_q;
    gnt_count_d = gnt_count_q;
    grant_new   = 1'b0;
    win         = 2'd0;
`ifdef ARB_TIMEOUT_EN
    timeout_d   = 1'b0;
    hold_cnt_d  = (state_q == GRANT) ? hold_cnt_q + 8'd1 : hold_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_new = 1'b1;
          win       = rr_pick(req, last_idx_q);
        end
      end
      GRANT: begin
        if (natural_rel || forced_rel) begin
          last_idx_d = cur_q;
`ifdef ARB_TIMEOUT_EN
          timeout_d  = forced_rel & ~natural_rel;
`endif
          if (|req) begin
            // Re-arbitrate on the release edge so valid never dips.
            grant_new = 1'b1;
            win       = rr_pick(req, cur_q);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            gnt_d   = 4'b0000;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_new) begin
      state_d     = GRANT;
      cur_d       = win;
      gnt_d       = 4'b0001 << win;
      valid_d     = 1'b1;
      gnt_count_d = gnt_count_q + CNT_W'(1);
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d  = 8'd0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= 2'd0;
      last_idx_q  <= 2'd3;
      gnt_q       <= 4'b0000;
      valid_q     <= 1'b0;
      gnt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_idx_q  <= last_idx_d;
      gnt_q       <= gnt_d;
      valid_q     <= valid_d;
      gnt_count_q <= gnt_count_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign s0        = cur_q[1];
  assign s1        = cur_q[0];
  assign valid     = valid_q;
  assign gnt_count = gnt_count_q;

endmodule

// File: tb/tb_rr_mux_select_arb.sv
// Directed bench for rr_mux_select_arb; the timeout scenario follows ARB_TIMEOUT_EN.
module tb_rr_mux_select_arb;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       s0;
  logic       s1;
  logic       valid;
  logic [7:0] gnt_count;
  logic       timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rr_mux_select_arb #(
    .CNT_W    (8),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .s0        (s0),
    .s1        (s1),
    .valid     (valid),
    .gnt_count (gnt_count),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] g, input logic [7:0] cnt);
    check({tag, " gnt"}, 32'(gnt), 32'(g));
    check({tag, " sel"}, 32'({s0, s1}), 32'($clog2(g)));
    check({tag, " valid"}, 32'(valid), 32'd1);
    check({tag, " count"}, 32'(gnt_count), 32'(cnt));
  endtask

  initial begin
    logic [3:0] rot [4];
    rot[0] = 4'b0010; rot[1] = 4'b0100; rot[2] = 4'b1000; rot[3] = 4'b0001;

    // Reset held with all requesters active.
    reset = 1'b1;
    req   = 4'b1111;
    done  = 1'b0;
    repeat (3) step();
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst valid", 32'(valid), 32'd0);
    check("rst sel", 32'({s0, s1}), 32'd0);
    check("rst count", 32'(gnt_count), 32'd0);
    check("rst timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    step();
    expect_grant("first", 4'b0001, 8'd1);

    // Rotation a -> b -> c -> d -> a with done asserted every cycle.
    done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_grant($sformatf("rot%0d", i), rot[i], 8'(i + 2));
    end

    // Bring ownership to b, then sparse request 1010 must skip c and land on d.
    req = 4'b1111;
    step();
    expect_grant("to_b", 4'b0010, 8'd6);
    req = 4'b1010;
    step();
    expect_grant("sparse", 4'b1000, 8'd7);
    req = 4'b0010;
    step();
    expect_grant("sole_b", 4'b0010, 8'd8);
    step();
    expect_grant("regrant_b", 4'b0010, 8'd9);

    // Move to c, hold it, then drop the request without done.
    req = 4'b0100;
    step();
    expect_grant("to_c", 4'b0100, 8'd10);
    done = 1'b0;
    step();
    expect_grant("hold_c", 4'b0100, 8'd10);
    req = 4'b0000;
    step();
    check("drop gnt", 32'(gnt), 32'd0);
    check("drop valid", 32'(valid), 32'd0);
    check("drop sel_held", 32'({s0, s1}), 32'd2);
    step();
    check("idle valid", 32'(valid), 32'd0);
    req = 4'b0001;
    #1;
    check("no_comb gnt", 32'(gnt), 32'd0);
    done = 1'b1;
    #1;
    check("done_idle valid", 32'(valid), 32'd0);
    done = 1'b0;
    step();
    expect_grant("latency_a", 4'b0001, 8'd11);

    // Move to d, then assert reset between clock edges.
    req  = 4'b1000;
    done = 1'b1;
    step();
    expect_grant("to_d", 4'b1000, 8'd12);
    done = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async gnt", 32'(gnt), 32'd0);
    check("async valid", 32'(valid), 32'd0);
    check("async sel", 32'({s0, s1}), 32'd0);
    check("async count", 32'(gnt_count), 32'd0);
    req = 4'b0000;
    step();
    #1;
    reset = 1'b0;

    // Post-reset search restarts at a; with only c asking, c wins.
    req = 4'b0100;
    step();
    expect_grant("post_rst_c", 4'b0100, 8'd1);

    // Hold scenario: a and b request, done never asserted.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req = 4'b0011;
    step();
    expect_grant("hold_a", 4'b0001, 8'd1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("to_hold%0d gnt", i), 32'(gnt), 32'd1);
      check($sformatf("to_hold%0d timeout", i), 32'(timeout), 32'd0);
    end
    step();
    expect_grant("to_b_forced", 4'b0010, 8'd2);
    check("to_pulse", 32'(timeout), 32'd1);
    step();
    check("to_pulse_end", 32'(timeout), 32'd0);
    check("to_b_held", 32'(gnt), 32'd2);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      check($sformatf("hold%0d gnt", i), 32'(gnt), 32'd1);
      check($sformatf("hold%0d timeout", i), 32'(timeout), 32'd0);
    end
    check("hold count", 32'(gnt_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
